// File: rtl/activity_led_ctrl.sv
// activity_led_ctrl
//   Multi-channel activity LED controller. Each channel turns single-cycle
//   activity strobes into a burst of PULSES blinks, each 2^COUNTER_WIDTH
//   cycles long, or holds its LED statically off/on. A shared 8-bit PWM
//   stage applies a global brightness to every channel.
//
// Parameters
//   NUM_CH        number of independent channels (>=1)
//   COUNTER_WIDTH blink period is 2^COUNTER_WIDTH cycles (>=2)
//   PULSES        blinks per burst (>=1)
//
// Ports
//   clk        clock
//   rst_n      asynchronous active-low reset
//   trigger    per-channel activity strobe
//   mode       channel i uses mode[2i+1:2i]:
//              00 off, 01 on, 10 burst, 11 burst retriggerable
//   brightness global PWM duty (0 dark, 255 full)
//   led_out    registered LED drive
//   busy       registered, high while the channel is mid-burst
module activity_led_ctrl #(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned COUNTER_WIDTH = 25,
  parameter int unsigned PULSES        = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_CH-1:0]     trigger,
  input  logic [2*NUM_CH-1:0]   mode,
  input  logic [7:0]            brightness,
  output logic [NUM_CH-1:0]     led_out,
  output logic [NUM_CH-1:0]     busy
);

  localparam int unsigned PW = (PULSES > 1) ? $clog2(PULSES) : 1;
  localparam logic [PW-1:0] LAST_PIDX = PW'(PULSES - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  logic [NUM_CH-1:0] raw;
  logic [NUM_CH-1:0] busy_d;
  logic [7:0]        pwm_cnt_q;
  logic              pwm_on;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_t                   state_q, state_d;
    logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic [PW-1:0]            pidx_q, pidx_d;
    logic [1:0]               ch_mode;

    assign ch_mode = mode[2*g +: 2];

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pidx_d  = pidx_q;
      raw[g]  = 1'b0;
      if (!ch_mode[1]) begin
        // Static modes abort any burst in progress.
        state_d = IDLE;
        cnt_d   = '0;
        pidx_d  = '0;
        raw[g]  = ch_mode[0];
      end else begin
        raw[g] = (state_q == ACTIVE) & cnt_q[COUNTER_WIDTH-1];
        if (state_q == IDLE) begin
          cnt_d  = '0;
          pidx_d = '0;
          if (trigger[g]) state_d = ACTIVE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          // Retrigger restarts the pulse count but leaves cnt running so
          // the blink phase is continuous; it also overrides end-of-burst.
          if (ch_mode[0] && trigger[g]) begin
            pidx_d = '0;
          end else if (&cnt_q) begin
            if (pidx_q == LAST_PIDX) begin
              state_d = IDLE;
              pidx_d  = '0;
            end else begin
              pidx_d = pidx_q + 1'b1;
            end
          end
        end
      end
    end

    assign busy_d[g] = (state_d == ACTIVE);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        pidx_q  <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        pidx_q  <= pidx_d;
      end
    end
  end

  assign pwm_on = (brightness == 8'hFF) | (pwm_cnt_q < brightness);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
      led_out   <= '0;
      busy      <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 8'd1;
      led_out   <= raw & {NUM_CH{pwm_on}};
      busy      <= busy_d;
    end
  end

endmodule
